// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - signal bundle between the UART receiver and its pin/consumer side
// Purpose : groups the serial input and the parallel byte/status outputs of uart_rx_fsm.
// Signals : i_rx         serial line, idles high
//           o_rx_data    last correctly framed byte
//           o_rx_valid   one-cycle pulse when o_rx_data updates
//           o_frame_err  one-cycle pulse when the stop bit samples 0
//           o_busy       high whenever the receiver is not idle
//           o_parity_err one-cycle pulse on even-parity mismatch (only with UART_RX_PARITY_EN)
// Modports: slave  - receiver side (drives the outputs)
//           master - pin driver / byte consumer side
// Macro   : UART_RX_PARITY_EN adds o_parity_err.
interface uart_rx_if;
    logic       i_rx;
    logic [7:0] o_rx_data;
    logic       o_rx_valid;
    logic       o_frame_err;
    logic       o_busy;
`ifdef UART_RX_PARITY_EN
    logic       o_parity_err;

    modport slave  (input i_rx, output o_rx_data, o_rx_valid, o_frame_err, o_busy, o_parity_err);
    modport master (output i_rx, input o_rx_data, o_rx_valid, o_frame_err, o_busy, o_parity_err);
`else
    modport slave  (input i_rx, output o_rx_data, o_rx_valid, o_frame_err, o_busy);
    modport master (output i_rx, input o_rx_data, o_rx_valid, o_frame_err, o_busy);
`endif
endinterface

// File: rtl/uart_rx_fsm.sv
// rtl/uart_rx_fsm.sv - 8N1 UART receiver with mid-bit sampling
// Purpose : deserialises an asynchronous serial line (start 0, 8 data bits LSB first,
//           optional even parity bit, stop 1) into a parallel byte.
// Ports   : clk    system clock, rising edge
//           rst_n  asynchronous active-low reset
//           rx_if  uart_rx_if.slave (i_rx in; o_rx_data, o_rx_valid, o_frame_err,
//                  o_busy and, with parity, o_parity_err out)
// Macro   : UART_RX_PARITY_EN inserts a PARITY state after D7 and enables o_parity_err.
module uart_rx_fsm #(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD_RATE = 115200
) (
    input  logic     clk,
    input  logic     rst_n,
    uart_rx_if.slave rx_if
);
    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_BIT - 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    state_t           r_state;
    state_t           w_next_state;
    logic             r_rx_meta;
    logic             r_rx_s;
    logic             r_rx_d;
    logic [CNT_W-1:0] r_baud_cnt;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_shift;
    logic [7:0]       r_rx_data;
    logic             r_rx_valid;
    logic             r_frame_err;
    logic             r_parity_err;
    logic             w_start_edge;
    logic             w_sample;
    logic             w_shift_en;
    logic             w_load;
    logic             w_frame_err;
    logic             w_parity_err;
`ifdef UART_RX_PARITY_EN
    logic             r_par_bit;
    logic             w_par_en;
`endif

    assign w_start_edge = r_rx_d & ~r_rx_s;

    // Synchroniser resets high so an idle line produces no false start edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
            r_rx_d    <= 1'b1;
        end else begin
            r_rx_meta <= rx_if.i_rx;
            r_rx_s    <= r_rx_meta;
            r_rx_d    <= r_rx_s;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        w_sample     = 1'b0;
        w_shift_en   = 1'b0;
        w_load       = 1'b0;
        w_frame_err  = 1'b0;
        w_parity_err = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_par_en     = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                if (w_start_edge) w_next_state = S_START;
            end
            S_START: begin
                // A line that is high again at the start-bit centre was only a glitch.
                if (r_baud_cnt == CNT_HALF) begin
                    w_sample     = 1'b1;
                    w_next_state = r_rx_s ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (r_baud_cnt == CNT_LAST) begin
                    w_sample   = 1'b1;
                    w_shift_en = 1'b1;
                    if (r_bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        w_next_state = S_PARITY;
`else
                        w_next_state = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (r_baud_cnt == CNT_LAST) begin
                    w_sample     = 1'b1;
                    w_par_en     = 1'b1;
                    w_next_state = S_STOP;
                end
            end
`endif
            S_STOP: begin
                // Returning to IDLE at the stop-bit centre leaves half a bit to catch
                // the next start edge of a back-to-back frame.
                if (r_baud_cnt == CNT_LAST) begin
                    w_sample     = 1'b1;
                    w_next_state = S_IDLE;
                    w_frame_err  = ~r_rx_s;
`ifdef UART_RX_PARITY_EN
                    w_parity_err = ^{r_shift, r_par_bit};
`endif
                    w_load       = r_rx_s & ~w_parity_err;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_baud_cnt   <= '0;
            r_bit_idx    <= 3'd0;
            r_shift      <= 8'h00;
            r_rx_data    <= 8'h00;
            r_rx_valid   <= 1'b0;
            r_frame_err  <= 1'b0;
            r_parity_err <= 1'b0;
        end else begin
            if (r_state == S_IDLE || w_sample || w_next_state != r_state)
                r_baud_cnt <= '0;
            else
                r_baud_cnt <= r_baud_cnt + 1'b1;

            if (r_state != S_DATA) r_bit_idx <= 3'd0;
            else if (w_shift_en)   r_bit_idx <= r_bit_idx + 3'd1;

            // LSB arrives first, so shifting right leaves D0 in bit 0 after eight bits.
            if (w_shift_en) r_shift <= {r_rx_s, r_shift[7:1]};

            if (w_load) r_rx_data <= r_shift;
            r_rx_valid   <= w_load;
            r_frame_err  <= w_frame_err;
            r_parity_err <= w_parity_err;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        r_par_bit <= 1'b0;
        else if (w_par_en) r_par_bit <= r_rx_s;
    end

    assign rx_if.o_parity_err = r_parity_err;
`endif

    assign rx_if.o_rx_data   = r_rx_data;
    assign rx_if.o_rx_valid  = r_rx_valid;
    assign rx_if.o_frame_err = r_frame_err;
    assign rx_if.o_busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_fsm.sv
// tb/tb_uart_rx_fsm.sv - self-checking bench for uart_rx_fsm
module tb_uart_rx_fsm;
    localparam int CLK_FREQ = 50_000_000;
    localparam int BAUD     = 115200;
    localparam int CLKS     = CLK_FREQ / BAUD;
    localparam int LAT_MIN  = (19 * CLKS) / 2 + 3;
    localparam int LAT_MAX  = (19 * CLKS) / 2 + 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    uart_rx_if rx_if ();

    uart_rx_fsm #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .rx_if (rx_if)
    );

    int          n_chk = 0;
    int          n_err = 0;
    int unsigned cyc   = 0;
    int unsigned start_cyc = 0;
    int unsigned last_valid_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Monitor: collects every pulse the DUT emits.
    logic [7:0] got_q[$];
    int         got_ferr = 0;
    int         got_perr = 0;
    logic       prev_pulse = 1'b0;

    always @(negedge clk) begin
        logic perr;
        logic any;
        perr = 1'b0;
`ifdef UART_RX_PARITY_EN
        perr = rx_if.o_parity_err;
`endif
        any = rx_if.o_rx_valid | rx_if.o_frame_err | perr;
        if (rx_if.o_rx_valid) begin
            got_q.push_back(rx_if.o_rx_data);
            last_valid_cyc = cyc;
        end
        if (rx_if.o_frame_err) got_ferr++;
        if (perr) got_perr++;
        if (any) begin
            check("pulse_exclusive", {31'd0, rx_if.o_rx_valid & (rx_if.o_frame_err | perr)}, 32'd0);
            check("pulse_width", {31'd0, prev_pulse}, 32'd0);
        end
        prev_pulse = any;
    end

    // Reference model: outcome of a whole frame from its bits.
    logic [7:0] exp_q[$];
    int         exp_ferr = 0;
    int         exp_perr = 0;
    logic [7:0] exp_data = 8'h00;

    task automatic model_frame(input logic [7:0] d, input logic stop_b, input logic par_b);
        logic par_ok;
`ifdef UART_RX_PARITY_EN
        par_ok = (((^d) ^ par_b) == 1'b0);
`else
        par_ok = 1'b1 | par_b;
`endif
        if (!stop_b) exp_ferr++;
        if (!par_ok) exp_perr++;
        if (stop_b && par_ok) begin
            exp_q.push_back(d);
            exp_data = d;
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_b);
        logic bits[$];
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(d[i]);
`ifdef UART_RX_PARITY_EN
        bits.push_back(par_b);
`endif
        bits.push_back(stop_b);
        model_frame(d, stop_b, par_b);
        for (int k = 0; k < bits.size(); k++) begin
            if (k == 0) start_cyc = cyc;
            rx_if.i_rx = bits[k];
            tick(CLKS);
        end
        rx_if.i_rx = 1'b1;
    endtask

    task automatic wait_idle(input string tag);
        int k;
        k = 0;
        while (rx_if.o_busy && k < 2000) begin
            tick(1);
            k++;
        end
        check({tag, "_idle"}, {31'd0, rx_if.o_busy}, 32'd0);
    endtask

    task automatic check_all(input string tag);
        tick(5);
        check({tag, "_nvalid"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check({tag, "_byte"}, {24'd0, got_q[i]}, {24'd0, exp_q[i]});
        check({tag, "_nframe_err"}, got_ferr, exp_ferr);
        check({tag, "_nparity_err"}, got_perr, exp_perr);
        check({tag, "_rx_data"}, {24'd0, rx_if.o_rx_data}, {24'd0, exp_data});
        check({tag, "_valid_low"}, {31'd0, rx_if.o_rx_valid}, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d;
        logic       stop_b;
        logic       par_b;
        int         k;
        int unsigned lat;

        // 1: reset and quiet idle line
        rx_if.i_rx = 1'b1;
        rst_n = 1'b0;
        tick(10);
        check("rst_busy", {31'd0, rx_if.o_busy}, 32'd0);
        check("rst_data", {24'd0, rx_if.o_rx_data}, 32'd0);
        rst_n = 1'b1;
        tick(1);
        check("post_rst_valid", {31'd0, rx_if.o_rx_valid}, 32'd0);
        check("post_rst_ferr", {31'd0, rx_if.o_frame_err}, 32'd0);
        tick(1000);
        check_all("idle");
        check("idle_busy", {31'd0, rx_if.o_busy}, 32'd0);

        // 2: single good frame plus latency
        send_frame(8'hA5, 1'b1, ^8'hA5);
        wait_idle("a5");
        check_all("a5");
        lat = last_valid_cyc - start_cyc;
        check("a5_latency", {31'd0, (lat >= LAT_MIN && lat <= LAT_MAX)}, 32'd1);

        // 3: short low glitch is rejected
        rx_if.i_rx = 1'b0;
        tick(50);
        check("glitch_busy", {31'd0, rx_if.o_busy}, 32'd1);
        tick(50);
        rx_if.i_rx = 1'b1;
        k = 0;
        while (rx_if.o_busy && k < 220) begin
            tick(1);
            k++;
        end
        check("glitch_idle", {31'd0, rx_if.o_busy}, 32'd0);
        check_all("glitch");

        // 4: bad stop bit
        send_frame(8'h3C, 1'b0, ^8'h3C);
        wait_idle("ferr");
        check_all("ferr");
        check("ferr_held_a5", {24'd0, rx_if.o_rx_data}, 32'hA5);

        // 5: back-to-back frames with no idle gap
        send_frame(8'h00, 1'b1, ^8'h00);
        send_frame(8'hFF, 1'b1, ^8'hFF);
        send_frame(8'h81, 1'b1, ^8'h81);
        wait_idle("b2b");
        check_all("b2b");

        // 6: reset in the middle of bit 4 aborts the frame
        d = 8'h96;
        rx_if.i_rx = 1'b0;
        tick(CLKS);
        for (int i = 0; i < 4; i++) begin
            rx_if.i_rx = d[i];
            tick(CLKS);
        end
        rx_if.i_rx = d[4];
        tick(CLKS / 2);
        rst_n = 1'b0;
        tick(1);
        exp_data = 8'h00;
        check("abort_busy", {31'd0, rx_if.o_busy}, 32'd0);
        check("abort_data", {24'd0, rx_if.o_rx_data}, 32'd0);
        rx_if.i_rx = 1'b1;
        tick(5);
        rst_n = 1'b1;
        tick(10);
        check_all("abort");
`ifdef UART_RX_PARITY_EN
        send_frame(8'h5A, 1'b1, 1'b1);
`else
        send_frame(8'h5A, 1'b1, ^8'h5A);
`endif
        wait_idle("5a");
        check_all("5a");

        // 7: random frames with occasional bad stop / parity
        for (int n = 0; n < 4; n++) begin
            d      = 8'($urandom);
            stop_b = ($urandom_range(0, 3) != 0);
            par_b  = (^d) ^ ($urandom_range(0, 3) == 0);
            send_frame(d, stop_b, par_b);
            wait_idle("rnd");
            check_all("rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
